// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-port encodings and requester state type
package mem_pkg;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ = 1'b1;
   localparam int WORD_BYTES = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} req_state_t;
endpackage

// File: rtl/mem_requester_addr_check.sv
// addr_check: word alignment and legal-window check on a byte address
module addr_check import mem_pkg::*; #(
   parameter logic [31:0] BASE = 32'h0,
   parameter logic [31:0] BYTES = 32'h1000
) (
   input  logic [31:0] addr,
   output logic        ok
);
   // 33-bit bounds so a window touching the top of the address space cannot wrap
   localparam logic [32:0] LO = {1'b0, BASE};
   localparam logic [32:0] HI = {1'b0, BASE} + {1'b0, BYTES} - 33'(WORD_BYTES);
   always_comb ok = addr[1:0] == 2'b00 && {1'b0, addr} >= LO && {1'b0, addr} <= HI;
endmodule

// File: rtl/mem_requester.sv
// mem_requester: one-at-a-time word request controller driving the mem port set
module mem_requester import mem_pkg::*; #(
   parameter int          RD_LATENCY = 1,
   parameter logic [31:0] MEM_BASE = 32'h0,
   parameter logic [31:0] MEM_BYTES = 32'h1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr_32,
   output logic [31:0] mem_data_in_32,
   input  logic [31:0] mem_data_out_32,
   output logic        mem_rw,
   output logic        mem_en
);
   typedef struct packed {
      req_state_t  state;
      logic [2:0]  cnt;
      logic        ready;
      logic        valid;
      logic        err;
      logic        en;
      logic        rw;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
   } regs_t;
   localparam regs_t RST = '{state: IDLE, cnt: 3'd0, ready: 1'b0, valid: 1'b0, err: 1'b0,
                             en: 1'b0, rw: RW_READ, rdata: 32'd0, addr: 32'd0, wdata: 32'd0};
   regs_t r, n;
   logic legal, accept;
   addr_check #(.BASE(MEM_BASE), .BYTES(MEM_BYTES)) u_check (.addr(req_addr), .ok(legal));
   assign accept = req_valid && r.ready;
   always_ff @(posedge clock or posedge reset)
      if (reset) r <= RST;
      else r <= n;
   // every output is a register; this block only computes their next values
   always_comb begin
      n = r;
      n.valid = 1'b0;
      n.err = 1'b0;
      n.en = 1'b0;
      unique case (r.state)
         IDLE: begin
            n.ready = !accept;
            if (accept) begin
               n.state = legal ? ISSUE : RESP;
               n.valid = !legal;
               n.err = !legal;
               n.en = legal;
               n.rdata = legal ? r.rdata : 32'd0;
               n.addr = legal ? req_addr : r.addr;
               n.wdata = legal ? req_wdata : r.wdata;
               n.rw = legal ? req_rw : r.rw;
            end
         end
         ISSUE: begin
            n.rw = RW_READ;
            n.state = r.rw == RW_READ ? WAIT : RESP;
            n.cnt = 3'(RD_LATENCY);
            n.valid = r.rw == RW_WRITE;
            n.rdata = r.rw == RW_WRITE ? 32'd0 : r.rdata;
         end
         WAIT: begin
            n.cnt = r.cnt - 3'd1;
            n.state = r.cnt == 3'd1 ? RESP : WAIT;
            n.valid = r.cnt == 3'd1;
            n.rdata = r.cnt == 3'd1 ? mem_data_out_32 : r.rdata;
         end
         RESP: begin
            n.state = IDLE;
            n.ready = 1'b1;
            n.rw = RW_READ;
         end
      endcase
   end
   assign req_ready = r.ready;
   assign resp_valid = r.valid;
   assign resp_rdata = r.rdata;
   assign resp_err = r.err;
   assign mem_addr_32 = r.addr;
   assign mem_data_in_32 = r.wdata;
   assign mem_rw = r.rw;
   assign mem_en = r.en;
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed checks of mem_requester against behavioural mem models
module tb_mem_requester import mem_pkg::*;;
   logic clock = 1'b0, reset = 1'b1;
   logic req_valid = 1'b0, req_rw = RW_READ, req_sel = 1'b0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic rdy1, val1, err1, rw1, en1, rdy2, val2, err2, rw2, en2;
   logic [31:0] rd1, ad1, di1, do1, rd2, ad2, di2, do2;
   logic o_ready, o_valid, o_err, o_rw, o_en;
   logic [31:0] o_rdata, o_addr, o_din;
   logic [31:0] mem1 [0:1023];
   logic [31:0] mem2 [0:1023];
   logic [31:0] p0, p1, p2;
   int npass = 0, ntot = 0, cyc = 0;
   int acc [4];
   logic [31:0] bb_addr [4] = '{32'h8, 32'h0, 32'h4, 32'h8};
   logic [31:0] bb_exp [4] = '{32'h12341234, 32'hABCDABCD, 32'hDEFADEFA, 32'h12341234};

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mem_requester u1 (
      .clock(clock), .reset(reset), .req_valid(req_valid && !req_sel), .req_ready(rdy1),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(val1),
      .resp_rdata(rd1), .resp_err(err1), .mem_addr_32(ad1), .mem_data_in_32(di1),
      .mem_data_out_32(do1), .mem_rw(rw1), .mem_en(en1));
   mem_requester #(.RD_LATENCY(3)) u2 (
      .clock(clock), .reset(reset), .req_valid(req_valid && req_sel), .req_ready(rdy2),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(val2),
      .resp_rdata(rd2), .resp_err(err2), .mem_addr_32(ad2), .mem_data_in_32(di2),
      .mem_data_out_32(do2), .mem_rw(rw2), .mem_en(en2));

   always @(posedge clock) begin
      if (en1 && rw1 == RW_WRITE) mem1[ad1[11:2]] <= di1;
      if (en1 && rw1 == RW_READ) do1 <= mem1[ad1[11:2]];
      if (en2 && rw2 == RW_WRITE) mem2[ad2[11:2]] <= di2;
      if (en2 && rw2 == RW_READ) p0 <= mem2[ad2[11:2]];
      p1 <= p0;
      p2 <= p1;
   end
   assign do2 = p2;

   assign o_ready = req_sel ? rdy2 : rdy1;
   assign o_valid = req_sel ? val2 : val1;
   assign o_err = req_sel ? err2 : err1;
   assign o_rw = req_sel ? rw2 : rw1;
   assign o_en = req_sel ? en2 : en1;
   assign o_rdata = req_sel ? rd2 : rd1;
   assign o_addr = req_sel ? ad2 : ad1;
   assign o_din = req_sel ? di2 : di1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      assert (got === exp) npass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!o_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk({tag, " ready"}, o_ready, 1'b1);
   endtask

   task automatic xact(input logic sel, input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat, input string tag);
      int k = 0, en = 0;
      req_sel = sel; req_rw = rw; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      wait_ready(tag);
      @(posedge clock); #1;
      req_valid = 1'b0; req_rw = ~rw; req_addr = 32'hDEADBEEF; req_wdata = 32'hDEADBEEF;
      chk({tag, " ready drop"}, o_ready, 1'b0);
      while (!o_valid && k < 20) begin
         if (o_en) begin
            en++;
            chk({tag, " issue addr"}, o_addr, addr);
            chk({tag, " issue rw"}, o_rw, rw);
            if (rw == RW_WRITE) chk({tag, " issue data"}, o_din, wdata);
         end else begin
            chk({tag, " wait addr"}, o_addr, addr);
            chk({tag, " wait rw"}, o_rw, RW_READ);
         end
         chk({tag, " busy"}, o_ready, 1'b0);
         @(posedge clock); #1;
         k++;
      end
      chk({tag, " latency"}, k, exp_lat);
      chk({tag, " en cycles"}, en, exp_err ? 0 : 1);
      chk({tag, " err"}, o_err, exp_err);
      chk({tag, " rdata"}, o_rdata, exp_rdata);
      chk({tag, " en at resp"}, o_en, 1'b0);
      chk({tag, " rw at resp"}, o_rw, RW_READ);
      @(posedge clock); #1;
      chk({tag, " valid clear"}, o_valid, 1'b0);
      chk({tag, " err clear"}, o_err, 1'b0);
      chk({tag, " ready back"}, o_ready, 1'b1);
      chk({tag, " rdata hold"}, o_rdata, exp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      #12;
      chk("rst ready", rdy1, 1'b0);
      chk("rst valid", val1, 1'b0);
      chk("rst err", err1, 1'b0);
      chk("rst en", en1, 1'b0);
      chk("rst rdata", rd1, 32'd0);
      chk("rst addr", ad1, 32'd0);
      chk("rst din", di1, 32'd0);
      chk("rst rw", rw1, RW_READ);
      reset = 1'b0;
      #1 chk("ready before edge", rdy1, 1'b0);
      @(posedge clock); #1;
      chk("ready first edge", rdy1, 1'b1);

      xact(0, RW_WRITE, 32'h0, 32'hABCDABCD, 32'd0, 0, 1, "wr0");
      xact(0, RW_WRITE, 32'h4, 32'hDEFADEFA, 32'd0, 0, 1, "wr4");
      xact(0, RW_WRITE, 32'h8, 32'h12341234, 32'd0, 0, 1, "wr8");
      xact(0, RW_READ, 32'h0, 32'h0, 32'hABCDABCD, 0, 2, "rd0");
      xact(0, RW_READ, 32'h4, 32'h0, 32'hDEFADEFA, 0, 2, "rd4");
      xact(0, RW_READ, 32'h8, 32'h0, 32'h12341234, 0, 2, "rd8");
      xact(0, RW_WRITE, 32'hFFC, 32'h5A5A5A5A, 32'd0, 0, 1, "wr top");
      xact(0, RW_READ, 32'hFFC, 32'h0, 32'h5A5A5A5A, 0, 2, "rd top");
      xact(0, RW_READ, 32'h6, 32'h0, 32'd0, 1, 0, "rd misaligned");
      xact(0, RW_WRITE, 32'h1000, 32'h11111111, 32'd0, 1, 0, "wr past end");
      xact(0, RW_READ, 32'hFFFFFFFC, 32'h0, 32'd0, 1, 0, "rd wrap");

      req_sel = 1'b0; req_rw = RW_READ; req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr = bb_addr[i];
         wait_ready("b2b");
         @(posedge clock); #1;
         acc[i] = cyc;
         if (i > 0) chk("b2b spacing", acc[i] - acc[i-1], 4);
         k = 0;
         while (!val1 && k < 20) begin
            chk("b2b busy", rdy1, 1'b0);
            @(posedge clock); #1;
            k++;
         end
         chk("b2b latency", k, 2);
         chk("b2b rdata", rd1, bb_exp[i]);
      end
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         chk("b2b no extra resp", val1, 1'b0);
         chk("b2b no extra en", en1, 1'b0);
      end

      req_sel = 1'b0; req_rw = RW_WRITE; req_addr = 32'h4; req_wdata = 32'hBAD0BAD0; req_valid = 1'b1;
      wait_ready("rst issue");
      @(posedge clock); #1;
      chk("rst issue en before", en1, 1'b1);
      chk("rst issue rw before", rw1, RW_WRITE);
      reset = 1'b1;
      #1;
      chk("rst issue en", en1, 1'b0);
      chk("rst issue rw", rw1, RW_READ);
      req_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 chk("rst issue no resp", val1, 1'b0);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("rst issue ready", rdy1, 1'b1);

      req_rw = RW_READ; req_addr = 32'h4; req_valid = 1'b1;
      wait_ready("rst wait");
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      chk("rst wait in wait", en1 || val1, 1'b0);
      reset = 1'b1;
      #1;
      chk("rst wait en", en1, 1'b0);
      chk("rst wait rw", rw1, RW_READ);
      chk("rst wait ready", rdy1, 1'b0);
      repeat (3) begin
         @(posedge clock); #1;
         chk("rst wait no resp", val1, 1'b0);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      xact(0, RW_READ, 32'h4, 32'h0, 32'hDEFADEFA, 0, 2, "rd after rst");

      xact(1, RW_WRITE, 32'h8, 32'h77778888, 32'd0, 0, 1, "lat3 wr8");
      xact(1, RW_READ, 32'h8, 32'h0, 32'h77778888, 0, 4, "lat3 rd8");

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
